// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_pkg
// Purpose  : Shared definitions for the pipeline boundary stages: occupancy
//            encodings and default payload widths per stage boundary.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Occupancy of a boundary stage; doubles as the skid state encoding.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Default payload widths for each boundary of the five-stage core.
  localparam int IFID_DATA_W  = 64;   // PC + instruction
  localparam int IFID_CTRL_W  = 1;
  localparam int IDEX_DATA_W  = 192;  // PC, rs1/rs2 values, immediate
  localparam int IDEX_CTRL_W  = 12;
  localparam int EXMEM_DATA_W = 128;  // ALU result, store data, PC
  localparam int EXMEM_CTRL_W = 6;
  localparam int MEMWB_DATA_W = 96;   // writeback value, PC, rd
  localparam int MEMWB_CTRL_W = 4;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Up-counter with synchronous clear that sticks at all-ones
//            instead of wrapping. Clear wins over increment.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear first, otherwise increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Valid/ready pipeline boundary register with flush, bubble
//            control zeroing, optional 2-entry skid buffer (registered
//            in_ready) and a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [1:0]        occ,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  logic              w_out_valid;
  logic              w_in_ready;
  logic [1:0]        w_occ;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_main_ctrl;

  if (SKID != 0) begin : g_skid
    occ_e              occ_q, occ_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q, in_ready_d;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign w_in_xfer  = in_valid & in_ready_q;
    assign w_out_xfer = (occ_q != OCC_EMPTY) & out_ready;

    // Next-state: FIFO of main+skid; flush kills entries but keeps data.
    always_comb begin
      occ_d       = occ_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (flush) begin
        occ_d       = OCC_EMPTY;
        main_ctrl_d = '0;
        skid_ctrl_d = '0;
      end else begin
        case (occ_q)
          OCC_EMPTY: begin
            if (w_in_xfer) begin
              occ_d       = OCC_ONE;
              main_data_d = in_data;
              main_ctrl_d = in_ctrl;
            end
          end
          OCC_ONE: begin
            if (w_in_xfer && w_out_xfer) begin
              main_data_d = in_data;
              main_ctrl_d = in_ctrl;
            end else if (w_in_xfer) begin
              occ_d       = OCC_TWO;
              skid_data_d = in_data;
              skid_ctrl_d = in_ctrl;
            end else if (w_out_xfer) begin
              occ_d = OCC_EMPTY;
            end
          end
          OCC_TWO: begin
            // in_ready is low here, so only the drain case matters.
            if (w_out_xfer) begin
              occ_d       = OCC_ONE;
              main_data_d = skid_data_q;
              main_ctrl_d = skid_ctrl_q;
            end
          end
          default: occ_d = OCC_EMPTY;
        endcase
      end
      // Registering from the next occupancy keeps out_ready off the path.
      in_ready_d = (occ_d != OCC_TWO);
    end

    // State and entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        occ_q       <= OCC_EMPTY;
        main_data_q <= '0;
        main_ctrl_q <= '0;
        skid_data_q <= '0;
        skid_ctrl_q <= '0;
        in_ready_q  <= 1'b1;
      end else begin
        occ_q       <= occ_d;
        main_data_q <= main_data_d;
        main_ctrl_q <= main_ctrl_d;
        skid_data_q <= skid_data_d;
        skid_ctrl_q <= skid_ctrl_d;
        in_ready_q  <= in_ready_d;
      end
    end

    assign w_out_valid = (occ_q != OCC_EMPTY);
    assign w_in_ready  = in_ready_q;
    assign w_occ       = occ_q;
    assign w_main_data = main_data_q;
    assign w_main_ctrl = main_ctrl_q;
  end else begin : g_single
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign w_in_ready = !valid_q | out_ready;
    assign w_in_xfer  = in_valid & w_in_ready;
    assign w_out_xfer = valid_q & out_ready;

    // Next-state: flush, then load, then drain, otherwise hold.
    always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;
      if (flush) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end else if (w_in_xfer) begin
        valid_d = 1'b1;
        data_d  = in_data;
        ctrl_d  = in_ctrl;
      end else if (w_out_xfer) begin
        valid_d = 1'b0;
      end
    end

    // Single entry register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        ctrl_q  <= '0;
      end else begin
        valid_q <= valid_d;
        data_q  <= data_d;
        ctrl_q  <= ctrl_d;
      end
    end

    assign w_out_valid = valid_q;
    assign w_occ       = {1'b0, valid_q};
    assign w_main_data = data_q;
    assign w_main_ctrl = ctrl_q;
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (w_out_valid & ~out_ready),
    .clr_i (stall_clr),
    .cnt_o (stall_cnt)
  );

  assign out_valid = w_out_valid;
  assign in_ready  = w_in_ready;
  assign occ       = w_occ;
  assign out_data  = w_main_data;
  // A bubble never carries live control bits.
  assign out_ctrl  = w_out_valid ? w_main_ctrl : '0;

endmodule : pipe_stage_skid
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Purpose  : Scoreboard bench for pipe_stage_skid, skid and single variants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // SKID=1 instance (a_*)
  logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [31:0] a_in_data = 0, a_out_data;
  logic [3:0]  a_in_ctrl = 0, a_out_ctrl;
  logic        a_flush = 0, a_stall_clr = 0;
  logic [1:0]  a_occ;
  logic [3:0]  a_stall;

  // SKID=0 instance (b_*)
  logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [31:0] b_in_data = 0, b_out_data;
  logic [3:0]  b_in_ctrl = 0, b_out_ctrl;
  logic        b_flush = 0, b_stall_clr = 0;
  logic [1:0]  b_occ;
  logic [3:0]  b_stall;

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(4), .SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_ctrl(a_out_ctrl),
    .flush(a_flush), .occ(a_occ), .stall_cnt(a_stall), .stall_clr(a_stall_clr)
  );

  pipe_stage_skid #(.DATA_W(32), .CTRL_W(4), .SKID(0), .CNT_W(4)) u_single (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .flush(b_flush), .occ(b_occ), .stall_cnt(b_stall), .stall_clr(b_stall_clr)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [35:0] q_a[$];
  logic [35:0] q_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the skid instance: pop on output transfer, push on input.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_a.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        if (q_a.size() == 0) chk("a_unexpected_out", {32'd0, a_out_data}, 64'hDEAD);
        else chk("a_out_order", {28'd0, a_out_data, a_out_ctrl}, {28'd0, q_a.pop_front()});
      end
      if (!a_out_valid) chk("a_bubble_ctrl", {60'd0, a_out_ctrl}, 64'd0);
      if (a_flush) q_a.delete();
      else if (a_in_valid && a_in_ready) q_a.push_back({a_in_data, a_in_ctrl});
    end
  end

  // Monitor for the single-register instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      q_b.delete();
    end else begin
      if (b_out_valid && b_out_ready) begin
        if (q_b.size() == 0) chk("b_unexpected_out", {32'd0, b_out_data}, 64'hDEAD);
        else chk("b_out_order", {28'd0, b_out_data, b_out_ctrl}, {28'd0, q_b.pop_front()});
      end
      if (!b_out_valid) chk("b_bubble_ctrl", {60'd0, b_out_ctrl}, 64'd0);
      if (b_flush) q_b.delete();
      else if (b_in_valid && b_in_ready) q_b.push_back({b_in_data, b_in_ctrl});
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    #12;
    // Reset state
    chk("rst_a_out_valid", a_out_valid, 0);
    chk("rst_a_in_ready", a_in_ready, 1);
    chk("rst_a_occ", a_occ, 0);
    chk("rst_a_stall", a_stall, 0);
    chk("rst_a_out_data", a_out_data, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    chk("rst_b_occ", b_occ, 0);
    @(posedge clk); #2 rst_n = 1'b1;
    step();

    // 1: streaming with out_ready=1
    a_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1; a_in_data = 32'h10 + i; a_in_ctrl = 4'hA;
      step();
      chk("t1_occ", a_occ, 1);
      chk("t1_out_data", a_out_data, 32'h10 + i);
      chk("t1_out_ctrl", a_out_ctrl, 4'hA);
      chk("t1_stall", a_stall, 0);
    end
    a_in_valid = 0;
    step();
    chk("t1_drain_occ", a_occ, 0);

    // 2: fill both entries under backpressure, then drain
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h20; a_in_ctrl = 4'h3;
    step();
    chk("t2_occ1", a_occ, 1);
    chk("t2_in_ready1", a_in_ready, 1);
    a_in_data = 32'h21; a_in_ctrl = 4'h4;
    step();
    a_in_valid = 0;
    chk("t2_occ2", a_occ, 2);
    chk("t2_in_ready0", a_in_ready, 0);
    chk("t2_stall1", a_stall, 1);
    chk("t2_hold_data", a_out_data, 32'h20);
    step();
    chk("t2_stall2", a_stall, 2);
    chk("t2_hold_data2", a_out_data, 32'h20);
    a_out_ready = 1;
    step();
    chk("t2_drain_occ1", a_occ, 1);
    chk("t2_drain_data", a_out_data, 32'h21);
    step();
    chk("t2_drain_occ0", a_occ, 0);
    chk("t2_stall_kept", a_stall, 2);

    // 3: flush at occ=2 with a simultaneous input, then at occ=1
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h22; a_in_ctrl = 4'h5; step();
    a_in_data = 32'h23; step();
    chk("t3_occ2", a_occ, 2);
    a_flush = 1; a_in_data = 32'h30; a_in_ctrl = 4'hF;
    step();
    a_flush = 0; a_in_valid = 0;
    chk("t3_out_valid", a_out_valid, 0);
    chk("t3_out_ctrl", a_out_ctrl, 0);
    chk("t3_occ0", a_occ, 0);
    chk("t3_in_ready", a_in_ready, 1);
    a_in_valid = 1; a_in_data = 32'h31; a_in_ctrl = 4'h6; step();
    chk("t3_occ1", a_occ, 1);
    chk("t3_in_ready1", a_in_ready, 1);
    a_flush = 1; a_in_data = 32'h32; step();
    a_flush = 0; a_in_valid = 0;
    chk("t3b_occ0", a_occ, 0);
    chk("t3b_in_ready", a_in_ready, 1);
    a_out_ready = 1;
    step(); step();
    chk("t3_nothing_left", a_out_valid, 0);

    // 5: stall counter saturation and clear priority
    a_stall_clr = 1; step(); a_stall_clr = 0;
    chk("t5_cleared", a_stall, 0);
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h50; a_in_ctrl = 4'h7; step();
    a_in_valid = 0;
    chk("t5_start", a_stall, 0);
    for (int i = 0; i < 15; i++) step();
    chk("t5_at_15", a_stall, 15);
    for (int i = 0; i < 5; i++) step();
    chk("t5_saturated", a_stall, 15);
    a_stall_clr = 1; step(); a_stall_clr = 0;
    chk("t5_clr_prio", a_stall, 0);
    step();
    chk("t5_after_clr", a_stall, 1);
    a_out_ready = 1; step();
    chk("t5_drained", a_occ, 0);

    // 4: single register, toggling out_ready with held upstream data
    j = 0;
    for (int i = 0; i < 10; i++) begin
      b_in_valid = 1; b_in_data = 32'h70 + j; b_in_ctrl = 4'h9;
      b_out_ready = (i % 2 == 0);
      #1;
      chk("t4_out_valid", b_out_valid, (q_b.size() != 0));
      chk("t4_in_ready", b_in_ready, (q_b.size() == 0) || b_out_ready);
      chk("t4_occ", b_occ, (q_b.size() != 0) ? 2'd1 : 2'd0);
      if (b_in_ready) j++;
      step();
    end
    b_in_valid = 0; b_out_ready = 1;
    step(); step();
    chk("t4_drained", b_out_valid, 0);
    chk("t4_queue_empty", q_b.size(), 0);

    // 6: asynchronous reset with occ=2, then 1-cycle latency
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = 32'h60; a_in_ctrl = 4'h1; step();
    a_in_data = 32'h61; step();
    a_in_valid = 0;
    chk("t6_occ2", a_occ, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_out_valid", a_out_valid, 0);
    chk("t6_out_ctrl", a_out_ctrl, 0);
    chk("t6_occ", a_occ, 0);
    chk("t6_stall", a_stall, 0);
    chk("t6_in_ready", a_in_ready, 1);
    @(posedge clk); #2 rst_n = 1'b1;
    a_out_ready = 1;
    a_in_valid = 1; a_in_data = 32'h40; a_in_ctrl = 4'h2;
    step();
    a_in_valid = 0;
    chk("t6_lat_valid", a_out_valid, 1);
    chk("t6_lat_data", a_out_data, 32'h40);
    step();
    chk("t6_end_occ", a_occ, 0);
    chk("end_queue_a", q_a.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_pipe_stage_skid
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline boundary register for the five-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the fixed free-running stage registers with a valid/ready-handshaked stage.
- Adds flush, bubble insertion, an optional 2-entry skid buffer that registers the ready path, and a saturating stall counter.
- The datapath payload and control payload are separate buses, so bubbles can zero control without touching data.

Parameters:
- DATA_W, 128: width of datapath payload (PC, instruction, imm, ALU result, etc. concatenated by the instantiating stage).
- CTRL_W, 8: width of control payload (we_rf, wd_sel, mem we, etc.). Must be ≥1.
- SKID, 1:
  - 1 = 2-entry skid buffer with registered in_ready.
  - 0 = single register with combinational in_ready.
- CNT_W, 16: width of the saturating stall counter.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- in_valid, input, 1: upstream stage holds a valid instruction.
- in_ready, output, 1: this stage accepts in_* this cycle.
- in_data, input, DATA_W: upstream datapath payload.
- in_ctrl, input, CTRL_W: upstream control payload.
- out_valid, output, 1: out_* holds a valid instruction.
- out_ready, input, 1: downstream consumes out_* this cycle.
- out_data, output, DATA_W: datapath payload to next stage.
- out_ctrl, output, CTRL_W: control payload; forced to all-zero whenever out_valid=0.
- flush, input, 1: synchronous kill of all held entries (branch/jump redirect).
- occ, output, 2: number of entries held (0..2; never exceeds 1 when SKID=0).
- stall_cnt, output, CNT_W: count of cycles with out_valid=1 and out_ready=0; saturates at all-ones.
- stall_clr, input, 1: synchronous clear of stall_cnt.

Behaviour:
- Reset (async, rst_n=0) sets all of the following to 0: both entries' valid, data and ctrl; occ; stall_cnt; out_valid; out_ctrl; out_data.
  - in_ready is 1 in reset when SKID=1, and is 1 in reset when SKID=0.
  - Reset mid-transfer discards all entries with no partial output.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Latency is 1 cycle: data accepted at edge N appears on out_* after edge N when the stage was empty.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - The register loads in_* on an input transfer.
  - It clears valid on an output transfer with no input transfer.
  - It holds otherwise.
- SKID=1 state machine, state = occ:
  - EMPTY (0):
    - Input transfer → ONE.
    - Output is main entry.
  - ONE (1):
    - Input transfer with output transfer → ONE (main entry reloads).
    - Input transfer without output transfer → TWO (skid entry loads in_*).
    - Output transfer only → EMPTY.
  - TWO (2):
    - in_ready=0.
    - Output transfer → ONE; the skid entry moves to main in the same edge.
  - in_ready is a registered version of (occ != 2), with no combinational path from out_ready.
- Ordering: strict FIFO; the skid entry never overtakes the main entry.
- flush:
  - At the next edge, all entries are invalidated, occ=0, and stored ctrl is zeroed.
  - flush has priority over a same-cycle input transfer; that input is dropped even though in_ready=1 was shown.
  - stored data is left unchanged.
  - in_ready returns to 1 the cycle after flush.
- Bubble: an invalid out_* always presents ctrl=0, so we_rf/mem-write cannot fire on a bubble. out_data is don't-care when invalid.
- stall_cnt:
  - Increments by 1 per cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - stall_clr takes priority over increment (result 0).
  - Not affected by flush.
- No X propagation: every register has a defined reset value.

Decomposition:
- Shared package `pipe_pkg` holds:
  - occ encodings OCC_EMPTY=2'd0, OCC_ONE=2'd1, OCC_TWO=2'd2.
  - Default CTRL_W/DATA_W constants per stage boundary: IFID, IDEX, EXMEM, MEMWB widths.
- One natural sub-module: `sat_counter`, parametrised by CNT_W, with inc/clr and saturation; it is used for stall_cnt.
- The skid logic stays inline under a generate on SKID.

Test Plan:
1. SKID=1, DATA_W=32, CTRL_W=4, out_ready=1, in_valid=1 for 4 cycles with data 0x10..0x13, ctrl 4'hA → out_data 0x10..0x13 one cycle later in order; occ stays 1; stall_cnt=0.
2. SKID=1, send 0x20 and 0x21, out_ready=0 → occ=2; in_ready=0 the cycle after; out_data holds 0x20; stall_cnt counts 1 per cycle. Raise out_ready → 0x20 then 0x21; occ 2→1→0.
3. occ=2, assert flush with a simultaneous in_valid=1, data 0x30 → next cycle out_valid=0, out_ctrl=0, occ=0, in_ready=1; 0x30 never appears.
4. SKID=0, out_ready toggling 1,0,1,0 with continuous input → in_ready equals !out_valid|out_ready each cycle; no data loss or duplication (scoreboard).
5. CNT_W=4, out_valid=1 and out_ready=0 for 20 cycles → stall_cnt saturates at 15. stall_clr with a held stall → 0, then 1 the next cycle.
6. rst_n low asynchronously mid-cycle with occ=2 → immediately out_valid=0, out_ctrl=0, occ=0, stall_cnt=0. After release, first input 0x40 emerges with 1-cycle latency.
